sudoku_board_store: RTL and testbench

//  81-cell Sudoku board storage and cursor controller between the button debouncers and SudokuSolver.
//  - Consumes single-cycle Prev/Next/Enter pulses (debouncer SCEN) and switch InputValue.
//  - Drives Row/Col/OutputValue to the SSD scan logic and the LEDs.
//  - Gives the solver a row/col read/write port while Lock is high.

---
 rtl/sudoku_board_store_if.sv | 36 +++
 rtl/sudoku_board_store.sv | 213 +++++++++++++++++++++
 tb/tb_sudoku_board_store.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sudoku_board_store_if.sv
// Bundles the user-control, solver and display signals of sudoku_board_store.
// master drives the buttons/switches/solver inputs; slave is the board store itself.
interface sudoku_board_store_if #(
  parameter int CELL_W = 4
);
  logic              Prev;
  logic              Next;
  logic              Enter;
  logic [CELL_W-1:0] InputValue;
  logic              ClearBoard;
  logic              Lock;
  logic              SolverWe;
  logic [3:0]        SolverRow;
  logic [3:0]        SolverCol;
  logic [CELL_W-1:0] SolverWData;
  logic [CELL_W-1:0] SolverRData;
  logic [3:0]        Row;
  logic [3:0]        Col;
  logic [CELL_W-1:0] OutputValue;
  logic              Given;
  logic              Reject;
  logic              Busy;
  logic              Conflict;

  modport master (
    output Prev, Next, Enter, InputValue, ClearBoard, Lock,
           SolverWe, SolverRow, SolverCol, SolverWData,
    input  SolverRData, Row, Col, OutputValue, Given, Reject, Busy, Conflict
  );

  modport slave (
    input  Prev, Next, Enter, InputValue, ClearBoard, Lock,
           SolverWe, SolverRow, SolverCol, SolverWData,
    output SolverRData, Row, Col, OutputValue, Given, Reject, Busy, Conflict
  );
endinterface

// File: rtl/sudoku_board_store.sv
// Sudoku board storage with user cursor, solver port and 81-cycle clear sweep.
// Optional row/column conflict scan after each entry: define SUDOKU_CONFLICT_CHECK_EN.
module sudoku_board_store #(
  parameter int DIM    = 9,
  parameter int CELL_W = 4
) (
  input logic                 board_clk,
  input logic                 Reset,
  sudoku_board_store_if.slave bus
);
  localparam int               CELLS    = DIM * DIM;
  localparam int               IDX_W    = $clog2(CELLS);
  localparam logic [3:0]       LAST_RC  = 4'(DIM - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);
  localparam logic [CELL_W-1:0] MAX_VAL = CELL_W'(DIM);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SCAN  = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] idx_of(input logic [3:0] r, input logic [3:0] c);
    return IDX_W'(r) * IDX_W'(DIM) + IDX_W'(c);
  endfunction

  logic [CELLS-1:0][CELL_W-1:0] cell_r;
  logic [CELLS-1:0]             given_r;
  state_t                       state_r;
  logic [IDX_W-1:0]             clr_idx_r;
  logic [3:0]                   row_r;
  logic [3:0]                   col_r;
  logic [CELL_W-1:0]            out_val_r;
  logic                         out_given_r;
  logic [CELL_W-1:0]            rdata_r;
  logic                         reject_r;
  logic                         busy_r;
  logic                         conflict_r;

  logic [IDX_W-1:0] cur_idx_s;
  logic [IDX_W-1:0] sol_idx_s;
  logic             idle_s;
  logic             sol_in_range_s;
  logic             enter_ok_s;
  logic             enter_rej_s;
  logic             clear_go_s;
  logic             sol_we_s;
  logic             move_fwd_s;
  logic             move_back_s;

  // Decode user and solver requests against the current state.
  always_comb begin
    cur_idx_s      = idx_of(row_r, col_r);
    sol_idx_s      = idx_of(bus.SolverRow, bus.SolverCol);
    idle_s         = (state_r == ST_IDLE);
    sol_in_range_s = (bus.SolverRow <= LAST_RC) && (bus.SolverCol <= LAST_RC);
    enter_ok_s     = bus.Enter && idle_s && !bus.Lock && (bus.InputValue <= MAX_VAL);
    enter_rej_s    = bus.Enter && !enter_ok_s;
    clear_go_s     = bus.ClearBoard && idle_s && !bus.Lock;
    sol_we_s       = bus.SolverWe && bus.Lock && sol_in_range_s;
    move_fwd_s     = idle_s && bus.Next && !bus.Prev;
    move_back_s    = idle_s && bus.Prev && !bus.Next;
  end

`ifdef SUDOKU_CONFLICT_CHECK_EN
  logic [3:0]        scan_cnt_r;
  logic              scan_hit_r;
  logic [CELL_W-1:0] scan_val_r;
  logic [3:0]        scan_row_r;
  logic [3:0]        scan_col_r;
  logic [3:0]        peer_k_s;
  logic [3:0]        peer_row_s;
  logic [3:0]        peer_col_s;
  logic              peer_hit_s;
  localparam logic [3:0] SCAN_LAST = 4'(2 * (DIM - 1) - 1);

  // Walk the row peers first, then the column peers, skipping the written cell.
  always_comb begin
    if (scan_cnt_r < LAST_RC) begin
      peer_k_s   = scan_cnt_r;
      peer_row_s = scan_row_r;
      peer_col_s = (peer_k_s < scan_col_r) ? peer_k_s : peer_k_s + 4'd1;
    end else begin
      peer_k_s   = scan_cnt_r - LAST_RC;
      peer_col_s = scan_col_r;
      peer_row_s = (peer_k_s < scan_row_r) ? peer_k_s : peer_k_s + 4'd1;
    end
    peer_hit_s = (cell_r[idx_of(peer_row_s, peer_col_s)] == scan_val_r);
  end
`endif

  // Row-major cursor with wrap at both ends of the board.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      row_r <= 4'd0;
      col_r <= 4'd0;
    end else if (move_fwd_s) begin
      if (col_r == LAST_RC) begin
        col_r <= 4'd0;
        row_r <= (row_r == LAST_RC) ? 4'd0 : row_r + 4'd1;
      end else begin
        col_r <= col_r + 4'd1;
      end
    end else if (move_back_s) begin
      if (col_r == 4'd0) begin
        col_r <= LAST_RC;
        row_r <= (row_r == 4'd0) ? LAST_RC : row_r - 4'd1;
      end else begin
        col_r <= col_r - 4'd1;
      end
    end
  end

  // Cell storage plus the clear/scan state machine; the sweep overrides same-cycle writes.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      cell_r     <= '0;
      given_r    <= '0;
      state_r    <= ST_IDLE;
      clr_idx_r  <= '0;
      busy_r     <= 1'b0;
      conflict_r <= 1'b0;
`ifdef SUDOKU_CONFLICT_CHECK_EN
      scan_cnt_r <= 4'd0;
      scan_hit_r <= 1'b0;
      scan_val_r <= '0;
      scan_row_r <= 4'd0;
      scan_col_r <= 4'd0;
`endif
    end else begin
      if (sol_we_s && !given_r[sol_idx_s]) begin
        cell_r[sol_idx_s] <= bus.SolverWData;
      end
      if (enter_ok_s) begin
        cell_r[cur_idx_s]  <= bus.InputValue;
        given_r[cur_idx_s] <= (bus.InputValue != '0);
      end
      case (state_r)
        ST_IDLE: begin
          if (clear_go_s) begin
            state_r    <= ST_CLEAR;
            clr_idx_r  <= '0;
            busy_r     <= 1'b1;
            conflict_r <= 1'b0;
          end
`ifdef SUDOKU_CONFLICT_CHECK_EN
          else if (enter_ok_s && (bus.InputValue != '0)) begin
            state_r    <= ST_SCAN;
            busy_r     <= 1'b1;
            scan_cnt_r <= 4'd0;
            scan_hit_r <= 1'b0;
            scan_val_r <= bus.InputValue;
            scan_row_r <= row_r;
            scan_col_r <= col_r;
          end else if (enter_ok_s) begin
            conflict_r <= 1'b0;
          end
`endif
        end
        ST_CLEAR: begin
          cell_r[clr_idx_r]  <= '0;
          given_r[clr_idx_r] <= 1'b0;
          if (clr_idx_r == LAST_IDX) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            clr_idx_r <= clr_idx_r + IDX_W'(1);
          end
        end
`ifdef SUDOKU_CONFLICT_CHECK_EN
        ST_SCAN: begin
          if (scan_cnt_r == SCAN_LAST) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            conflict_r <= scan_hit_r | peer_hit_s;
          end else begin
            scan_hit_r <= scan_hit_r | peer_hit_s;
            scan_cnt_r <= scan_cnt_r + 4'd1;
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Registered display and solver read-back; reads see the pre-write value.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      out_val_r   <= '0;
      out_given_r <= 1'b0;
      rdata_r     <= '0;
      reject_r    <= 1'b0;
    end else begin
      out_val_r   <= cell_r[cur_idx_s];
      out_given_r <= given_r[cur_idx_s];
      rdata_r     <= sol_in_range_s ? cell_r[sol_idx_s] : '0;
      reject_r    <= enter_rej_s;
    end
  end

  assign bus.Row         = row_r;
  assign bus.Col         = col_r;
  assign bus.OutputValue = out_val_r;
  assign bus.Given       = out_given_r;
  assign bus.SolverRData = rdata_r;
  assign bus.Reject      = reject_r;
  assign bus.Busy        = busy_r;
  assign bus.Conflict    = conflict_r;
endmodule

// File: tb/tb_sudoku_board_store.sv
// Scoreboard bench for sudoku_board_store: stimulus queues expected values with a due
// cycle, a negedge monitor compares them against the DUT outputs.
module tb_sudoku_board_store;
  logic board_clk = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  sudoku_board_store_if bus_if ();

  sudoku_board_store dut (
    .board_clk (board_clk),
    .Reset     (Reset),
    .bus       (bus_if)
  );

  always #5 board_clk = ~board_clk;
  always @(posedge board_clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    int         sel;
    logic [7:0] exp;
    string      nm;
  } exp_t;

  exp_t q[$];

  localparam int S_ROW = 0, S_COL = 1, S_OUT = 2, S_GIVEN = 3,
                 S_REJ = 4, S_BUSY = 5, S_CONF = 6, S_RDATA = 7;

  function automatic logic [7:0] dut_val(input int sel);
    case (sel)
      S_ROW:   dut_val = {4'd0, bus_if.Row};
      S_COL:   dut_val = {4'd0, bus_if.Col};
      S_OUT:   dut_val = {4'd0, bus_if.OutputValue};
      S_GIVEN: dut_val = {7'd0, bus_if.Given};
      S_REJ:   dut_val = {7'd0, bus_if.Reject};
      S_BUSY:  dut_val = {7'd0, bus_if.Busy};
      S_CONF:  dut_val = {7'd0, bus_if.Conflict};
      S_RDATA: dut_val = {4'd0, bus_if.SolverRData};
      default: dut_val = 8'hFF;
    endcase
  endfunction

  // Monitor: compare every queued expectation whose due cycle has arrived.
  always @(negedge board_clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due <= cyc) begin
        logic [7:0] act;
        act = dut_val(q[i].sel);
        checks++;
        if (q[i].due < cyc || act !== q[i].exp) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%0d want=%0d due=%0d", q[i].nm, cyc, act, q[i].exp, q[i].due);
        end
        q.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge board_clk);
      #1;
    end
  endtask

  task automatic exp_at(input string nm, input int sel, input int exp, input int lat);
    exp_t e;
    e.due = cyc + lat;
    e.sel = sel;
    e.exp = 8'(exp);
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic exp_cursor(input int r, input int c, input int v, input int g);
    exp_at("row", S_ROW, r, 0);
    exp_at("col", S_COL, c, 0);
    exp_at("outval", S_OUT, v, 0);
    exp_at("given", S_GIVEN, g, 0);
  endtask

  task automatic pulse_next();
    bus_if.Next = 1'b1; tick(1); bus_if.Next = 1'b0; tick(1);
  endtask

  task automatic pulse_prev();
    bus_if.Prev = 1'b1; tick(1); bus_if.Prev = 1'b0; tick(1);
  endtask

  task automatic enter(input int v);
    bus_if.InputValue = 4'(v); bus_if.Enter = 1'b1; tick(1); bus_if.Enter = 1'b0;
  endtask

  task automatic sol_read(input string nm, input int r, input int c, input int exp);
    bus_if.SolverRow = 4'(r); bus_if.SolverCol = 4'(c);
    exp_at(nm, S_RDATA, exp, 1);
    tick(1);
  endtask

  initial begin
    Reset = 1'b1;
    bus_if.Prev = 1'b0; bus_if.Next = 1'b0; bus_if.Enter = 1'b0;
    bus_if.InputValue = 4'd0; bus_if.ClearBoard = 1'b0; bus_if.Lock = 1'b0;
    bus_if.SolverWe = 1'b0; bus_if.SolverRow = 4'd0; bus_if.SolverCol = 4'd0;
    bus_if.SolverWData = 4'd0;
    tick(3);
    Reset = 1'b0;

    // reset state
    exp_cursor(0, 0, 0, 0);
    exp_at("rst_busy", S_BUSY, 0, 0);
    exp_at("rst_reject", S_REJ, 0, 0);
    exp_at("rst_conflict", S_CONF, 0, 0);
    exp_at("rst_rdata", S_RDATA, 0, 0);
    tick(2);

    // cursor walking and wrap
    for (int i = 0; i < 9; i++) pulse_next();
    exp_cursor(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) pulse_prev();
    exp_cursor(0, 0, 0, 0);
    pulse_prev();
    exp_at("wrap_back_row", S_ROW, 8, 0);
    exp_at("wrap_back_col", S_COL, 8, 0);
    bus_if.Prev = 1'b1; bus_if.Next = 1'b1; tick(1);
    bus_if.Prev = 1'b0; bus_if.Next = 1'b0; tick(1);
    exp_at("both_row", S_ROW, 8, 0);
    exp_at("both_col", S_COL, 8, 0);
    pulse_next();
    exp_at("wrap_fwd_row", S_ROW, 0, 0);
    exp_at("wrap_fwd_col", S_COL, 0, 0);

    // user entry at (2,3)
    bus_if.Next = 1'b1; tick(21); bus_if.Next = 1'b0; tick(1);
    exp_cursor(2, 3, 0, 0);
    exp_at("enter5_rej", S_REJ, 0, 1);
    enter(5);
    pulse_next();
    pulse_prev();
    tick(1);
    exp_cursor(2, 3, 5, 1);
    exp_at("enter12_rej", S_REJ, 1, 1);
    enter(12);
    exp_at("enter12_rej_end", S_REJ, 0, 1);
    tick(2);
    exp_at("enter12_keep", S_OUT, 5, 0);

    // enter with move: write at (2,4), land on (2,5)
    pulse_next();
    bus_if.Next = 1'b1;
    enter(9);
    bus_if.Next = 1'b0;
    tick(2);
    exp_cursor(2, 5, 0, 0);
    enter(3);
    tick(2);
    exp_cursor(2, 5, 3, 1);
    enter(0);
    tick(2);
    exp_cursor(2, 5, 0, 0);

    // solver port under lock
    bus_if.Lock = 1'b1;
    exp_at("lock_enter_rej", S_REJ, 1, 1);
    enter(4);
    bus_if.SolverWData = 4'd7; bus_if.SolverWe = 1'b1;
    sol_read("given_wr_old", 2, 3, 5);
    bus_if.SolverWe = 1'b0;
    sol_read("given_kept", 2, 3, 5);
    bus_if.SolverWe = 1'b1;
    sol_read("wr00_old", 0, 0, 0);
    bus_if.SolverWe = 1'b0;
    sol_read("wr00_new", 0, 0, 7);
    bus_if.SolverWData = 4'd6; bus_if.SolverWe = 1'b1;
    sol_read("oor_read", 9, 0, 0);
    bus_if.SolverWe = 1'b0;
    sol_read("oor_00_kept", 0, 0, 7);
    sol_read("oor_81_kept", 0, 1, 0);
    sol_read("enter_move_cell", 2, 4, 9);
    bus_if.Lock = 1'b0;
    bus_if.SolverWe = 1'b1;
    sol_read("unlocked_wr", 1, 1, 0);
    bus_if.SolverWe = 1'b0;
    sol_read("unlocked_ign", 1, 1, 0);

    // clear sweep: Busy for exactly 81 cycles
    bus_if.ClearBoard = 1'b1;
    for (int k = 1; k <= 81; k++) exp_at("clr_busy", S_BUSY, 1, k);
    exp_at("clr_busy_end", S_BUSY, 0, 82);
    tick(1);
    bus_if.ClearBoard = 1'b0;
    tick(8);
    exp_at("clr_enter_rej", S_REJ, 1, 1);
    enter(6);
    pulse_next();
    tick(30);
    bus_if.ClearBoard = 1'b1; tick(1); bus_if.ClearBoard = 1'b0;
    tick(45);
    exp_cursor(2, 5, 0, 0);
    sol_read("clr_23", 2, 3, 0);
    sol_read("clr_00", 0, 0, 0);
    sol_read("clr_24", 2, 4, 0);
    tick(2);

`ifdef SUDOKU_CONFLICT_CHECK_EN
    // conflict scan: 4 at (0,0), then 4 at (0,5)
    bus_if.Prev = 1'b1; tick(23); bus_if.Prev = 1'b0; tick(1);
    exp_at("scan_row", S_ROW, 0, 0);
    exp_at("scan_col", S_COL, 0, 0);
    bus_if.InputValue = 4'd4; bus_if.Enter = 1'b1;
    for (int k = 1; k <= 16; k++) exp_at("scan1_busy", S_BUSY, 1, k);
    exp_at("scan1_busy_end", S_BUSY, 0, 17);
    exp_at("scan1_conf", S_CONF, 0, 17);
    tick(1); bus_if.Enter = 1'b0;
    tick(20);
    bus_if.Next = 1'b1; tick(5); bus_if.Next = 1'b0; tick(1);
    bus_if.Enter = 1'b1;
    for (int k = 1; k <= 16; k++) exp_at("scan2_busy", S_BUSY, 1, k);
    exp_at("scan2_busy_end", S_BUSY, 0, 17);
    exp_at("scan2_conf", S_CONF, 1, 17);
    tick(1); bus_if.Enter = 1'b0;
    tick(20);
    exp_at("conf_hold", S_CONF, 1, 0);
    enter(0);
    exp_at("conf_clr", S_CONF, 0, 0);
    tick(2);
`else
    exp_at("conf_tied", S_CONF, 0, 0);
    tick(2);
`endif

    for (int i = 0; i < 200 && q.size() > 0; i++) tick(1);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
